tpu_host_sequencer: RTL and testbench
=====================================

# tpu_host_sequencer

Byte-stream front end that sits directly upstream of the TPU core pins (data byte in, control byte in, result byte out, done). It accepts a framed command (header plus 8 matrix bytes) over a valid/ready stream and buffers the payload. It then replays the payload to the core as an uninterrupted 8-cycle load burst with the mode flags held. Finally it captures the result bytes the core emits after done and returns them on a second valid/ready stream.

## Interface
Parameters:
- `RESULT_BYTES`, default 8: bytes captured from the core after done; result buffer depth.
- `TIMEOUT`, default 63: maximum cycles in WAIT before abort; counter width $clog2(TIMEOUT+1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 8: host command/payload byte.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: sequencer accepts byte; transfer when `s_valid & s_ready`.
- `tpu_ui_in` out 8: data byte to core.
- `tpu_uio_in` out 8: core control; bit0 load_en, bit1 transpose, bit2 activation, bits7:3 zero.
- `tpu_uo_out` in 8: core result byte.
- `tpu_done` in 1: core done flag.
- `m_data` out 8: result byte to host.
- `m_valid` out 1: result byte valid.
- `m_ready` in 1: host accepts result byte.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on bad header or timeout.

## Operation
- States: IDLE, FILL, BURST, WAIT, CAPTURE, DRAIN.
- IDLE: `s_ready`=1. Header byte fields: bit0 transpose, bit1 activation, bits7:2 reserved.
  - Reserved bits nonzero: byte dropped, `err` pulses, stay IDLE.
  - Valid header: latch flags, enter FILL.
- FILL: `s_ready`=1; bytes 0..7 written to staging buffer in order. On 8th accept, go to BURST.
- BURST: 8 cycles; `load_en`=1, `tpu_ui_in` = staged byte k in burst cycle k; then WAIT. Never stalls.
- Flags: transpose/activation drive `tpu_uio_in[2:1]` from first BURST cycle until last CAPTURE cycle; 0 otherwise.
- WAIT: counter increments each cycle.
  - `tpu_done`=1: enter CAPTURE; this cycle's `tpu_uo_out` is result byte 0.
  - Counter reaches TIMEOUT without done: `err` pulses, go to IDLE, no results emitted.
- CAPTURE: stores `tpu_uo_out` on RESULT_BYTES consecutive cycles (including the done cycle), then DRAIN. `tpu_done` is not re-checked.
- DRAIN: `m_valid`=1 while unsent bytes remain; byte advances on `m_valid & m_ready`. After final handshake, go to IDLE. `m_data` stays stable while `m_valid & ~m_ready`.
- `s_ready`=0 in BURST, WAIT, CAPTURE, DRAIN; no command overlap.
- `tpu_done` asserted in IDLE, FILL or BURST is ignored (stale result).
- Sequencer never resets the core; core reset is handled elsewhere.

## Timing
- Reset values: state IDLE, `s_ready`=1 (combinational from state), `tpu_ui_in`=0, `tpu_uio_in`=0, `m_valid`=0, `m_data`=0, `busy`=0, `err`=0. Buffers and counters cleared.
- Reset in any state: next edge returns to IDLE. `load_en` drops the cycle after `rst` is sampled. Partial payload and results are discarded.
- Payload latency: last payload accept at cycle t; `load_en`=1 at t+1..t+8 with byte k at t+1+k; `load_en`=0 at t+9 (WAIT).
- Capture: done first seen at cycle d; bytes sampled at d..d+RESULT_BYTES-1. `m_valid` first high at d+RESULT_BYTES.
- Timeout: entering WAIT at t+9, `err` pulses at t+9+TIMEOUT; IDLE and `s_ready`=1 next cycle.
- All outputs registered except `s_ready`, `busy` (decoded from state) and `m_valid` (state plus count).

## Structure
- Package `tpu_pkg`:
  - state enum;
  - header bit positions (HDR_TRANSPOSE=0, HDR_ACTIVATION=1);
  - control bit indices (UIO_LOAD_EN=0, UIO_TRANSPOSE=1, UIO_ACTIVATION=2);
  - PAYLOAD_BYTES=8.
- Sub-module `byte_buffer` (parameter DEPTH): indexed write/read with fill count, clear on `rst`. Instantiated twice: staging (DEPTH=8) and result (DEPTH=RESULT_BYTES).

## Test plan
- Header 0x03, payload 0x01..0x08, done 5 cycles after burst, core emits 0x10..0x17 -> `tpu_ui_in` 0x01..0x08 on 8 consecutive cycles with `tpu_uio_in`=0x07; `m_data` sequence 0x10..0x17.
- Header 0x84 -> `err` one-cycle pulse, `s_ready` stays 1, no `load_en`. Following header 0x00 processed normally.
- Payload with `s_valid` gaps of 0-3 cycles -> burst still 8 contiguous `load_en` cycles with bytes in order.
- `tpu_done` never asserted -> `err` exactly TIMEOUT cycles after entering WAIT, `m_valid` never high, new command accepted.
- `m_ready` toggled randomly in DRAIN -> all 8 bytes delivered once, in order, `m_data` stable while stalled. `tpu_done` pulsed during BURST ignored.
- `rst` asserted in burst cycle 4 -> `tpu_uio_in`=0 next cycle, state IDLE. Fresh command completes with correct data.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the TPU host sequencer.
//   state_t        - sequencer FSM states
//   HDR_*          - bit positions of the mode flags in the command header byte
//   UIO_*          - bit positions inside the core control byte (tpu_uio_in)
//   PAYLOAD_BYTES  - matrix bytes per command
package tpu_pkg;

  localparam int PAYLOAD_BYTES = 8;

  localparam int HDR_TRANSPOSE  = 0;
  localparam int HDR_ACTIVATION = 1;

  localparam int UIO_LOAD_EN    = 0;
  localparam int UIO_TRANSPOSE  = 1;
  localparam int UIO_ACTIVATION = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_BURST,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/byte_buffer.sv
// byte_buffer: small byte store written in arrival order, read by index.
//   clk, rst      - clock, synchronous active-high reset (clears contents)
//   i_clr         - synchronous clear (count and contents)
//   i_wr          - append i_wr_data at slot o_count (ignored when full)
//   i_rd_idx      - combinational read index -> o_rd_data
//   o_count       - number of bytes written since last clear
module byte_buffer #(
  parameter  int DEPTH = 8,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [7:0]    i_wr_data,
  input  logic [IW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data,
  output logic [CW-1:0] o_count
);

  localparam int unsigned NSLOT   = 2 ** IW;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  // Sized to a power of two so every read index is in range.
  logic [7:0]    r_mem [NSLOT];
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) r_mem[i] <= '0;
    end else if (i_wr && (r_count != C_DEPTH)) begin
      r_mem[r_count[IW-1:0]] <= i_wr_data;
      r_count                <= r_count + CW'(1);
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_count   = r_count;

endmodule

// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: host byte stream -> TPU core load burst -> result stream.
//   clk, rst                 - clock, synchronous active-high reset
//   s_data/s_valid/s_ready   - command stream: header byte then 8 payload bytes
//   tpu_ui_in                - data byte to core (registered)
//   tpu_uio_in               - core control: load_en, transpose, activation (registered)
//   tpu_uo_out, tpu_done     - core result byte and done flag
//   m_data/m_valid/m_ready   - result stream back to host
//   busy                     - any state other than IDLE
//   err                      - one-cycle pulse on bad header or WAIT timeout
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int RESULT_BYTES = 8,
  parameter int TIMEOUT      = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] tpu_ui_in,
  output logic [7:0] tpu_uio_in,
  input  logic [7:0] tpu_uo_out,
  input  logic       tpu_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       err
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int RW   = $clog2(RESULT_BYTES + 1);
  localparam int RIW  = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
  localparam int MW   = (TW > RW) ? TW : RW;
  localparam int CW   = (MW > 3) ? MW : 3;
  localparam int SCW  = $clog2(PAYLOAD_BYTES + 1);
  localparam int SIW  = $clog2(PAYLOAD_BYTES);

  localparam logic [CW-1:0]  C_TIMEOUT    = CW'(TIMEOUT);
  localparam logic [CW-1:0]  C_TIMEOUT_M1 = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  C_LAST_BURST = CW'(PAYLOAD_BYTES - 1);
  localparam logic [CW-1:0]  C_LAST_RES   = CW'(RESULT_BYTES - 1);
  localparam logic [RW-1:0]  C_RES_M1     = RW'(RESULT_BYTES - 1);
  localparam logic [SCW-1:0] C_STG_M1     = SCW'(PAYLOAD_BYTES - 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_flags;  // [0] transpose, [1] activation
  logic [7:0]      r_ui, r_uio, r_mdata;
  logic            r_err, w_err;

  logic            w_stg_wr, w_res_wr, w_clr;
  logic [SIW-1:0]  w_stg_ridx;
  logic [RIW-1:0]  w_res_ridx;
  logic [7:0]      w_stg_rd, w_res_rd;
  logic [SCW-1:0]  w_stg_count;
  logic [RW-1:0]   w_res_count;

  assign w_clr = (r_state == ST_IDLE);
  // Read one slot ahead so the registered outputs present slot k in cycle k.
  assign w_stg_ridx = (r_state == ST_BURST) ? SIW'(r_cnt + CW'(1)) : '0;
  assign w_res_ridx = (r_state == ST_DRAIN) ? RIW'(r_cnt + CW'(1)) : '0;

  byte_buffer #(.DEPTH(PAYLOAD_BYTES)) u_stage (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr      (w_stg_wr),
    .i_wr_data (s_data),
    .i_rd_idx  (w_stg_ridx),
    .o_rd_data (w_stg_rd),
    .o_count   (w_stg_count)
  );

  byte_buffer #(.DEPTH(RESULT_BYTES)) u_result (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_wr      (w_res_wr),
    .i_wr_data (tpu_uo_out),
    .i_rd_idx  (w_res_ridx),
    .o_rd_data (w_res_rd),
    .o_count   (w_res_count)
  );

  always_comb begin
    w_next   = r_state;
    w_stg_wr = 1'b0;
    w_res_wr = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          if (|s_data[7:2]) w_err  = 1'b1;
          else              w_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (s_valid) begin
          w_stg_wr = 1'b1;
          if (w_stg_count == C_STG_M1) w_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (r_cnt == C_LAST_BURST) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        // err is pulsed one cycle early so it lines up with the last WAIT cycle.
        if (r_cnt == C_TIMEOUT) begin
          w_next = ST_IDLE;
        end else if (tpu_done) begin
          w_res_wr = 1'b1;
          w_next   = (RESULT_BYTES == 1) ? ST_DRAIN : ST_CAPTURE;
        end else if (r_cnt == C_TIMEOUT_M1) begin
          w_err = 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_res_wr = 1'b1;
        if (w_res_count == C_RES_M1) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_ready && (r_cnt == C_LAST_RES)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_flags <= '0;
      r_ui    <= '0;
      r_uio   <= '0;
      r_mdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;

      if ((r_state == ST_IDLE) && (w_next == ST_FILL))
        r_flags <= {s_data[HDR_ACTIVATION], s_data[HDR_TRANSPOSE]};

      if (w_next != r_state)
        r_cnt <= '0;
      else if ((r_state inside {ST_BURST, ST_WAIT}) || ((r_state == ST_DRAIN) && m_ready))
        r_cnt <= r_cnt + CW'(1);

      r_ui  <= (w_next == ST_BURST) ? w_stg_rd : '0;
      r_uio <= '0;
      r_uio[UIO_LOAD_EN] <= (w_next == ST_BURST);
      if (w_next inside {ST_BURST, ST_WAIT, ST_CAPTURE}) begin
        r_uio[UIO_TRANSPOSE]  <= r_flags[0];
        r_uio[UIO_ACTIVATION] <= r_flags[1];
      end

      // With a single result byte, DRAIN is entered on the same edge that
      // stores it, so that byte is forwarded straight from the core.
      if (w_next != ST_DRAIN)
        r_mdata <= '0;
      else if (r_state != ST_DRAIN)
        r_mdata <= (RESULT_BYTES == 1) ? tpu_uo_out : w_res_rd;
      else if (m_ready)
        r_mdata <= w_res_rd;
    end
  end

  assign s_ready    = (r_state == ST_IDLE) || (r_state == ST_FILL);
  assign busy       = (r_state != ST_IDLE);
  assign m_valid    = (r_state == ST_DRAIN) && (r_cnt <= C_LAST_RES);
  assign tpu_ui_in  = r_ui;
  assign tpu_uio_in = r_uio;
  assign m_data     = r_mdata;
  assign err        = r_err;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
module tb_tpu_host_sequencer;

  localparam int RB = 8;
  localparam int TO = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] tpu_ui_in;
  logic [7:0] tpu_uio_in;
  logic [7:0] tpu_uo_out;
  logic       tpu_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [7:0] pay [8];
  logic [7:0] res [RB];

  always #5 clk = ~clk;

  tpu_host_sequencer #(.RESULT_BYTES(RB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tpu_ui_in  (tpu_ui_in),
    .tpu_uio_in (tpu_uio_in),
    .tpu_uo_out (tpu_uo_out),
    .tpu_done   (tpu_done),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    for (int i = 0; i < RB; i++) res[i] = 8'($urandom);
  endtask

  // One full command. done_delay < 0 means the core never finishes;
  // rst_at >= 0 aborts with a reset during that burst cycle.
  task automatic run_cmd(input logic [7:0] hdr, input int gap_max, input bit noisy_done,
                         input int rst_at, input int done_delay, input bit rand_ready);
    logic [7:0] flags;
    logic [7:0] prev;
    bit         stalled;
    int         n;
    int         idx;
    flags = {5'b0, hdr[1], hdr[0], 1'b0};

    check("hdr_ready", 32'(s_ready), 32'd1);
    s_data = hdr; s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    check("hdr_err", 32'(err), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        check("fill_ready", 32'(s_ready), 32'd1);
        check("fill_noload", 32'(tpu_uio_in), 32'd0);
        if (noisy_done) tpu_done = 1'($urandom_range(0, 1));
        s_data = 8'($urandom);
        tick;
      end
      s_data = pay[k]; s_valid = 1'b1;
      tick;
      s_valid = 1'b0;
    end
    tpu_done = 1'b0;

    for (int k = 0; k < 8; k++) begin
      check($sformatf("burst_ui%0d", k), 32'(tpu_ui_in), 32'(pay[k]));
      check("burst_uio", 32'(tpu_uio_in), 32'(flags | 8'h01));
      check("burst_ready", 32'(s_ready), 32'd0);
      if (k == rst_at) begin
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_uio", 32'(tpu_uio_in), 32'd0);
        check("rst_ui", 32'(tpu_ui_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        return;
      end
      tpu_done = noisy_done && (k == 2);
      tick;
    end
    tpu_done = 1'b0;
    check("wait_uio", 32'(tpu_uio_in), 32'(flags));
    check("wait_ui", 32'(tpu_ui_in), 32'd0);

    if (done_delay < 0) begin
      n = 0;
      while (!err && n < TO + 5) begin
        check("to_mvalid", 32'(m_valid), 32'd0);
        tick;
        n++;
      end
      check("to_cycles", 32'(n), 32'(TO));
      check("to_err", 32'(err), 32'd1);
      tick;
      check("to_err_pulse", 32'(err), 32'd0);
      check("to_ready", 32'(s_ready), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_uio", 32'(tpu_uio_in), 32'd0);
      return;
    end

    repeat (done_delay) begin
      check("wait_mvalid", 32'(m_valid), 32'd0);
      tpu_uo_out = 8'($urandom);
      tick;
    end
    for (int i = 0; i < RB; i++) begin
      tpu_done   = (i == 0);
      tpu_uo_out = res[i];
      check("cap_uio", 32'(tpu_uio_in), 32'(flags));
      check("cap_mvalid", 32'(m_valid), 32'd0);
      tick;
    end
    tpu_done   = 1'b0;
    tpu_uo_out = 8'($urandom);
    check("drain_uio", 32'(tpu_uio_in), 32'd0);

    idx = 0; n = 0; stalled = 1'b0; prev = '0;
    while (idx < RB && n < 200) begin
      check("drain_mvalid", 32'(m_valid), 32'd1);
      if (stalled) check("drain_stable", 32'(m_data), 32'(prev));
      check($sformatf("m_data%0d", idx), 32'(m_data), 32'(res[idx]));
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = !m_ready;
      prev    = m_data;
      if (m_ready) idx++;
      tick;
      n++;
    end
    m_ready = 1'b0;
    check("drain_count", 32'(idx), 32'(RB));
    check("end_mvalid", 32'(m_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; tpu_uo_out = '0; tpu_done = 1'b0; m_ready = 1'b0;
    tick;
    tick;
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_ui", 32'(tpu_ui_in), 32'd0);
    check("rst_uio", 32'(tpu_uio_in), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mdata", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick;

    // Directed: header 0x03, payload 1..8, results 0x10..0x17.
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    for (int i = 0; i < RB; i++) res[i] = 8'(8'h10 + i);
    run_cmd(8'h03, 0, 1'b0, -1, 5, 1'b0);

    // Reserved header bits set: dropped with an err pulse.
    s_data = 8'h84; s_valid = 1'b1;
    check("bad_ready", 32'(s_ready), 32'd1);
    tick;
    s_valid = 1'b0;
    check("bad_err", 32'(err), 32'd1);
    check("bad_ready_after", 32'(s_ready), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_uio", 32'(tpu_uio_in), 32'd0);
    tick;
    check("bad_err_pulse", 32'(err), 32'd0);
    check("bad_noload", 32'(tpu_uio_in), 32'd0);
    rand_data();
    run_cmd(8'h00, 0, 1'b0, -1, $urandom_range(0, 10), 1'b1);

    // Payload gaps of 0..3 cycles.
    rand_data();
    run_cmd(8'h01, 3, 1'b0, -1, $urandom_range(0, 20), 1'b1);

    // Core never reports done.
    rand_data();
    run_cmd(8'h02, 1, 1'b0, -1, -1, 1'b0);
    rand_data();
    run_cmd(8'h03, 0, 1'b0, -1, 2, 1'b0);

    // Random m_ready backpressure, stale done pulses in FILL and BURST.
    rand_data();
    run_cmd(8'h03, 2, 1'b1, -1, 7, 1'b1);

    // Reset in burst cycle 4, then a fresh command.
    rand_data();
    run_cmd(8'h03, 0, 1'b0, 4, 0, 1'b0);
    rand_data();
    run_cmd(8'h01, 1, 1'b0, -1, 3, 1'b1);

    // Done on the last cycle before timeout still captures.
    rand_data();
    run_cmd(8'h02, 0, 1'b0, -1, TO - 1, 1'b1);

    for (int c = 0; c < 6; c++) begin
      rand_data();
      run_cmd(8'($urandom_range(0, 3)), 3, 1'($urandom_range(0, 1)), -1,
              $urandom_range(0, 30), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
